// File: rtl/vga_capture.sv
// VGA sink: recovers pixel coordinates from a pixel-clocked hsync/vsync/RGB stream,
// checks the line/frame timing and reports an additive checksum per complete frame.
module vga_capture #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_TOTAL  = 800,
  parameter int   V_ACTIVE = 480,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_TOTAL  = 525,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        CPU_RESETN,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        px_valid,
  output logic [11:0] px_x,
  output logic [11:0] px_y,
  output logic [11:0] px_rgb,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_count,
  output logic [3:0]  err_flags
);

  localparam logic [11:0] K_MAX  = 12'(2 * H_TOTAL);
  localparam logic [11:0] K_PRE  = 12'(2 * H_TOTAL - 1);
  localparam logic [11:0] K_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_W   = 12'(H_SYNC);
  localparam logic [11:0] X_LO   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] X_HI   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  Y_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  Y_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  L_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        hs_was_on, vs_was_on;
  logic        hs_on, vs_on, hs_start, hs_end, vs_start;
  logic [11:0] k_reg, k_cur;
  logic [9:0]  l_reg, l_cur;
  logic        h_seen, v_pend;
  logic [11:0] hs_len;
  logic        meas_fail;
  logic [31:0] acc, acc_next;
  logic        err_period, err_width, err_vtot, err_tmo;
  logic [3:0]  fail_bits;
  logic        fail, in_win;

  assign hs_on    = (hsync == SYNC_POL);
  assign vs_on    = (vsync == SYNC_POL);
  assign hs_start = hs_on && !hs_was_on;
  assign hs_end   = !hs_on && hs_was_on;
  assign vs_start = vs_on && !vs_was_on;

  // k and l describe the sample arriving this cycle; the registered copies lag by one.
  always_comb begin
    k_cur = k_reg;
    if (hs_start)
      k_cur = 12'd0;
    else if (k_reg != K_MAX)
      k_cur = k_reg + 12'd1;

    l_cur = l_reg;
    if (hs_start && (vs_start || v_pend))
      l_cur = 10'd0;
    else if (hs_start && (l_reg != 10'h3FF))
      l_cur = l_reg + 10'd1;

    // A saturated k means the stall was already reported as a timeout.
    err_period = hs_start && h_seen && (k_reg != K_MAX) && (k_reg != K_LAST);
    err_width  = hs_end && (hs_len != HS_W);
    err_vtot   = vs_start && (l_reg != L_LAST);
    err_tmo    = !hs_start && (k_reg == K_PRE);

    fail_bits = (state == SEARCH) ? 4'b0000 : {err_tmo, err_vtot, err_width, err_period};
    fail      = |fail_bits;

    in_win = (k_cur >= X_LO) && (k_cur < X_HI) && (l_cur >= Y_LO) && (l_cur < Y_HI);

    acc_next = acc + (px_valid ? {20'd0, px_rgb} : 32'd0);
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      hs_was_on <= 1'b0;
      vs_was_on <= 1'b0;
      k_reg     <= 12'd0;
      l_reg     <= 10'd0;
      h_seen    <= 1'b0;
      v_pend    <= 1'b0;
      hs_len    <= 12'd0;
    end else begin
      hs_was_on <= hs_on;
      vs_was_on <= vs_on;
      k_reg     <= k_cur;
      l_reg     <= l_cur;
      if (hs_start)
        h_seen <= 1'b1;
      if (hs_start)
        v_pend <= 1'b0;
      else if (vs_start)
        v_pend <= 1'b1;
      if (hs_start)
        hs_len <= 12'd1;
      else if (hs_on && (hs_len != 12'hFFF))
        hs_len <= hs_len + 12'd1;
    end
  end

  // Lock state machine with all outputs registered; a failure in LOCKED drops
  // locked and px_valid on the very next cycle.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state      <= SEARCH;
      meas_fail  <= 1'b0;
      acc        <= 32'd0;
      locked     <= 1'b0;
      px_valid   <= 1'b0;
      px_x       <= 12'd0;
      px_y       <= 12'd0;
      px_rgb     <= 12'd0;
      frame_done <= 1'b0;
      frame_sum  <= 32'd0;
      frame_cnt  <= 16'd0;
      err_count  <= 8'd0;
      err_flags  <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      acc        <= acc_next;
      locked     <= (state == LOCKED);
      px_valid   <= (state == LOCKED) && !fail && in_win;
      if ((state == LOCKED) && !fail && in_win) begin
        px_x   <= k_cur - X_LO;
        px_y   <= {2'b00, l_cur - Y_LO};
        px_rgb <= rgb;
      end

      if (fail) begin
        err_flags <= err_flags | fail_bits;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end

      case (state)
        SEARCH: begin
          if (vs_start) begin
            state     <= MEASURE;
            meas_fail <= 1'b0;
          end
        end
        MEASURE: begin
          if (vs_start) begin
            if (!meas_fail && !fail) begin
              state  <= LOCKED;
              locked <= 1'b1;
              acc    <= 32'd0;
            end
            meas_fail <= 1'b0;
          end else if (fail) begin
            meas_fail <= 1'b1;
          end
        end
        LOCKED: begin
          if (fail) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end else if (vs_start) begin
            frame_sum  <= acc_next;
            frame_cnt  <= frame_cnt + 16'd1;
            frame_done <= 1'b1;
            acc        <= 32'd0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunken VGA timing so whole frames stay short.
module tb_vga_capture;

  localparam int H_ACTIVE = 16;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int H_TOTAL  = 28;
  localparam int V_ACTIVE = 6;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = 12;
  localparam int X0       = H_SYNC + H_BP;
  localparam int Y0       = V_SYNC + V_BP;

  logic        clk;
  logic        CPU_RESETN;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic        locked, px_valid, frame_done;
  logic [11:0] px_x, px_y, px_rgb;
  logic [31:0] frame_sum;
  logic [15:0] frame_cnt;
  logic [7:0]  err_count;
  logic [3:0]  err_flags;

  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          pix_seen = 0;
  logic [11:0] first_x, first_y, last_x, last_y;
  int          last_hc, last_vc;
  logic [11:0] last_rgb;
  logic [11:0] smp_cnt = 12'd0;
  bit          rgb_counter = 1'b0;
  logic [11:0] rgb_const = 12'hFFF;
  logic [31:0] win_sum = 32'd0;
  logic [31:0] prev_win_sum = 32'd0;

  vga_capture #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
    .err_count(err_count), .err_flags(err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // One generator sample per call; first scores the DUT outputs for the previous sample.
  task automatic applyStimulus(input bit hs_a, input bit vs_a, input int hc, input int vc);
    @(negedge clk);
    if (frame_done) done_seen++;
    if (px_valid) begin
      checkOutput("px_x", {20'd0, px_x}, 32'(12'(last_hc - X0)));
      checkOutput("px_y", {20'd0, px_y}, 32'(12'(last_vc - Y0)));
      checkOutput("px_rgb", {20'd0, px_rgb}, {20'd0, last_rgb});
      checkOutput("px_x_range", 32'(px_x < 12'(H_ACTIVE)), 32'd1);
      checkOutput("px_y_range", 32'(px_y < 12'(V_ACTIVE)), 32'd1);
      if (pix_seen == 0) begin
        first_x = px_x;
        first_y = px_y;
      end
      last_x = px_x;
      last_y = px_y;
      pix_seen++;
    end
    smp_cnt = smp_cnt + 12'd1;
    hsync = !hs_a;
    vsync = !vs_a;
    rgb = rgb_counter ? smp_cnt : rgb_const;
    if (hc >= X0 && hc < X0 + H_ACTIVE && vc >= Y0 && vc < Y0 + V_ACTIVE)
      win_sum = win_sum + {20'd0, rgb};
    last_hc = hc;
    last_vc = vc;
    last_rgb = rgb;
  endtask

  task automatic driveLine(input int vc, input int len, input int hsw);
    for (int hc = 0; hc < len; hc++)
      applyStimulus(hc < hsw, vc < V_SYNC, hc, vc);
  endtask

  // kind 1 shortens line sp by one clock, kind 2 widens its hsync pulse by one clock.
  task automatic driveFrame(input int nlines, input int sp, input int kind);
    prev_win_sum = win_sum;
    win_sum = 32'd0;
    for (int v = 0; v < nlines; v++)
      driveLine(v, (v == sp && kind == 1) ? H_TOTAL - 1 : H_TOTAL,
                (v == sp && kind == 2) ? H_SYNC + 1 : H_SYNC);
  endtask

  initial begin
    CPU_RESETN = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    rgb = 12'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_px_valid", 32'(px_valid), 32'd0);
    checkOutput("rst_px_x", {20'd0, px_x}, 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_frame_sum", frame_sum, 32'd0);
    checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("rst_err_flags", {28'd0, err_flags}, 32'd0);
    CPU_RESETN = 1'b1;

    // Acquire lock on ideal timing.
    rgb_const = 12'hFFF;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("A_locked", 32'(locked), 32'd0);
    checkOutput("A_err_count", {24'd0, err_count}, 32'd0);
    pix_seen = 0;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("B_locked", 32'(locked), 32'd1);
    checkOutput("B_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("B_pixels", 32'(pix_seen), 32'd96);
    checkOutput("B_first_x", {20'd0, first_x}, 32'd0);
    checkOutput("B_first_y", {20'd0, first_y}, 32'd0);
    checkOutput("B_last_x", {20'd0, last_x}, 32'd15);
    checkOutput("B_last_y", {20'd0, last_y}, 32'd5);

    rgb_counter = 1'b1;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("C_done_seen", 32'(done_seen), 32'd1);
    checkOutput("C_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    checkOutput("C_frame_sum", frame_sum, 32'd393120);

    rgb_counter = 1'b0;
    rgb_const = 12'h123;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("D_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    checkOutput("D_frame_sum_counter", frame_sum, prev_win_sum);

    // Short line while locked.
    driveFrame(V_TOTAL, 5, 1);
    checkOutput("E_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    checkOutput("E_frame_sum", frame_sum, 32'd27936);
    checkOutput("E_err_flags", {28'd0, err_flags}, 32'd1);
    checkOutput("E_err_count", {24'd0, err_count}, 32'd1);
    checkOutput("E_locked", 32'(locked), 32'd0);
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("F_locked", 32'(locked), 32'd0);
    checkOutput("F_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    rgb_const = 12'h0F0;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("G_locked", 32'(locked), 32'd1);
    checkOutput("G_done_seen", 32'(done_seen), 32'd3);
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("H_frame_cnt", {16'd0, frame_cnt}, 32'd4);
    checkOutput("H_frame_sum", frame_sum, 32'd23040);

    // hsync stalls for longer than two line periods.
    prev_win_sum = win_sum;
    win_sum = 32'd0;
    for (int v = 0; v < 3; v++) driveLine(v, H_TOTAL, H_SYNC);
    checkOutput("I_frame_cnt", {16'd0, frame_cnt}, 32'd5);
    for (int i = 0; i < 2 * H_TOTAL + 10; i++) applyStimulus(1'b0, 1'b0, 99, 99);
    checkOutput("I_err_flags", {28'd0, err_flags}, 32'd9);
    checkOutput("I_err_count", {24'd0, err_count}, 32'd2);
    checkOutput("I_locked", 32'(locked), 32'd0);
    driveFrame(V_TOTAL, -1, 0);
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("K_locked", 32'(locked), 32'd1);
    checkOutput("K_err_count", {24'd0, err_count}, 32'd2);

    // Asynchronous reset in the middle of a line.
    prev_win_sum = win_sum;
    win_sum = 32'd0;
    for (int v = 0; v < 5; v++) driveLine(v, H_TOTAL, H_SYNC);
    checkOutput("L_frame_cnt", {16'd0, frame_cnt}, 32'd6);
    #2 CPU_RESETN = 1'b0;
    #1;
    checkOutput("L_rst_locked", 32'(locked), 32'd0);
    checkOutput("L_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("L_rst_frame_sum", frame_sum, 32'd0);
    checkOutput("L_rst_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("L_rst_err_flags", {28'd0, err_flags}, 32'd0);
    checkOutput("L_rst_px_x", {20'd0, px_x}, 32'd0);
    checkOutput("L_rst_px_y", {20'd0, px_y}, 32'd0);
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    CPU_RESETN = 1'b1;
    rgb_const = 12'hFFF;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("M_locked", 32'(locked), 32'd0);
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("N_locked", 32'(locked), 32'd1);
    rgb_const = 12'h00F;
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("O_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    checkOutput("O_frame_sum", frame_sum, 32'd393120);

    // Wide hsync pulse, then a frame one line short.
    rgb_const = 12'h123;
    driveFrame(V_TOTAL, 3, 2);
    checkOutput("P_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    checkOutput("P_frame_sum", frame_sum, 32'd1440);
    checkOutput("P_err_flags", {28'd0, err_flags}, 32'd2);
    checkOutput("P_err_count", {24'd0, err_count}, 32'd1);
    checkOutput("P_locked", 32'(locked), 32'd0);
    driveFrame(V_TOTAL, -1, 0);
    driveFrame(V_TOTAL - 1, -1, 0);
    checkOutput("R_locked", 32'(locked), 32'd1);
    driveFrame(V_TOTAL, -1, 0);
    checkOutput("S_err_flags", {28'd0, err_flags}, 32'd6);
    checkOutput("S_err_count", {24'd0, err_count}, 32'd2);
    checkOutput("S_locked", 32'(locked), 32'd0);
    checkOutput("S_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // Long run of bad lines in MEASURE saturates the error counter.
    @(negedge clk);
    CPU_RESETN = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    CPU_RESETN = 1'b1;
    driveLine(0, H_TOTAL, H_SYNC);
    for (int v = 1; v <= 300; v++) begin
      driveLine(v, H_TOTAL - 1, H_SYNC);
      if (v == 100) checkOutput("sat_err_count_mid", {24'd0, err_count}, 32'd99);
    end
    driveLine(301, H_TOTAL, H_SYNC);
    checkOutput("sat_err_count", {24'd0, err_count}, 32'd255);
    checkOutput("sat_err_flags", {28'd0, err_flags}, 32'd1);
    checkOutput("sat_locked", 32'(locked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
